div_request_ctrl: RTL and testbench
===================================

# div_request_ctrl

Sequencing controller that sits between the integer execute stage and the multi-cycle unsigned division unit. It accepts RV32M DIV/DIVU/REM/REMU requests through a valid/ready handshake. It converts signed operands to magnitudes and resolves divide-by-zero and signed-overflow cases without starting the core. It launches the core, waits for completion, applies sign correction, and holds the result until the writeback stage takes it.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 5, destination-register tag width
- CLK  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rs1  in  XLEN  dividend
- req_rs2  in  XLEN  divisor
- req_tag  in  TAG_W  destination tag
- kill  in  1  pipeline flush; abandons the in-flight request
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_data  out  XLEN  quotient or remainder
- resp_tag  out  TAG_W  tag of the result
- busy  out  1  high in every state except IDLE
- div_valid  out  1  start pulse to the division core
- div_dividend  out  XLEN  unsigned magnitude to the core
- div_divisor  out  XLEN  unsigned magnitude to the core, never 0 when div_valid=1
- div_quotient  in  XLEN  core quotient
- div_remainder  in  XLEN  core remainder
- div_done  in  1  core completion (one-cycle pulse)

## Operation
- States: IDLE, LAUNCH, WAIT, FIXUP, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, register op, tag, neg_q, neg_r and the magnitudes.
  - Signed ops (DIV/REM): magnitude = two's-complement negation when bit XLEN-1 is set.
  - neg_q = sign(rs1) XOR sign(rs2), for signed ops only.
  - neg_r = sign(rs1), for signed ops only.
- Special cases, decided in IDLE; the core is not started and the next state is RESP:
  - rs2==0: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones, signed op only): DIV result = rs1; REM result = 0.
- Otherwise IDLE goes to LAUNCH.
- LAUNCH: div_valid=1 for exactly one cycle with the magnitudes driven; then WAIT.
- WAIT:
  - Stay until div_done.
  - On div_done, capture div_quotient or div_remainder (selected by op) and go to FIXUP.
- FIXUP:
  - Negate the captured value when (DIV and neg_q) or (REM and neg_r).
  - Negation is modulo 2^XLEN.
  - Load resp_data; then RESP.
- RESP:
  - resp_valid=1; resp_data and resp_tag are held stable.
  - On resp_ready, go to IDLE.
- kill:
  - In LAUNCH or WAIT: go to DRAIN. The core cannot be aborted.
  - In FIXUP or RESP: go to IDLE and drop resp_valid the next cycle.
  - In IDLE: the request in that same cycle is not accepted.
- DRAIN:
  - Wait for div_done, discard the result, then go to IDLE.
  - req_ready=0 in DRAIN.
  - Further kill pulses have no effect.
- kill has priority over resp_ready in the same cycle; no response is delivered in that case.

## Timing
- Reset values:
  - state IDLE, req_ready 1, resp_valid 0, resp_data 0, resp_tag 0, div_valid 0, busy 0.
  - div_dividend and div_divisor 0.
- req_ready and busy are decoded combinationally from state. All other outputs are registered.
- Special-case latency: accept at edge N, resp_valid high from N+1.
- Normal latency: accept at N; div_valid high in N+1; div_done arrives at N+1+L (L = core latency, not hard-coded); FIXUP takes 1 cycle; resp_valid high 2 cycles after the div_done cycle.
- Back-to-back operation: a new request can be accepted in the cycle after the resp handshake completes.
- Asynchronous reset mid-operation forces reset values immediately. The core is reset by the same rst_n.

## Test plan
- DIVU 100/7 -> after div_done, resp_data=14; REMU 100/7 -> 2; tag echoed.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF, resp_valid one cycle after accept, div_valid never pulses; REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; div_valid never pulses.
- kill during WAIT -> DRAIN, req_ready=0 until div_done, then IDLE. No resp_valid. The next request (DIVU 9/3) returns 3 correctly.
- resp_ready held low for 5 cycles -> resp_valid and resp_data remain stable. A request is not accepted until the handshake completes.

Source files
------------

// File: rtl/div_request_ctrl.sv
`default_nettype none
// ============================================================================
// div_request_ctrl : RV32M DIV/DIVU/REM/REMU sequencer around an unsigned
//                    multi-cycle divider (sign handling, special cases, flush).
// Revision: 1.0
// ============================================================================
module div_request_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             rst_n,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             kill,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,

  output logic             div_valid,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  input  logic             div_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FIXUP  = 3'd3,
    S_RESP   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;

  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_capt;
  logic             r_div_valid;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;

  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_data;
  logic             w_accept;
  logic             w_negate;

  // Request decode: bit 0 of the opcode marks the unsigned variants, bit 1 REM.
  assign w_signed = ~req_op[0];
  assign w_s1     = w_signed & req_rs1[XLEN-1];
  assign w_s2     = w_signed & req_rs2[XLEN-1];
  assign w_mag1   = w_s1 ? (~req_rs1 + 1'b1) : req_rs1;
  assign w_mag2   = w_s2 ? (~req_rs2 + 1'b1) : req_rs2;
  assign w_div0   = (req_rs2 == '0);
  assign w_ovf    = w_signed & (req_rs1 == c_INT_MIN) & (req_rs2 == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_accept  = (r_state == S_IDLE) & req_valid & ~kill;

  always_comb begin
    w_special_data = '0;
    if (w_div0) begin
      w_special_data = req_op[1] ? req_rs1 : '1;
    end else if (w_ovf) begin
      w_special_data = req_op[1] ? '0 : req_rs1;
    end
  end

  // Sign flags are only ever set for signed ops, so the op bit alone selects.
  assign w_negate = r_is_rem ? r_neg_r : r_neg_q;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_special ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_next = kill ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // A flush coinciding with completion has nothing left to drain.
        if (kill) begin
          w_next = div_done ? S_IDLE : S_DRAIN;
        end else if (div_done) begin
          w_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        w_next = kill ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (kill || resp_ready) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (div_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_rem     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_capt       <= '0;
      r_div_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      r_state      <= w_next;
      r_div_valid  <= (w_next == S_LAUNCH);
      r_resp_valid <= (w_next == S_RESP);

      if (w_accept) begin
        r_is_rem   <= req_op[1];
        r_neg_q    <= w_s1 ^ w_s2;
        r_neg_r    <= w_s1;
        r_dividend <= w_mag1;
        r_divisor  <= w_mag2;
        r_resp_tag <= req_tag;
        if (w_special) begin
          r_resp_data <= w_special_data;
        end
      end

      if ((r_state == S_WAIT) && div_done && !kill) begin
        r_capt <= r_is_rem ? div_remainder : div_quotient;
      end

      if ((r_state == S_FIXUP) && !kill) begin
        r_resp_data <= w_negate ? (~r_capt + 1'b1) : r_capt;
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign div_valid    = r_div_valid;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_tag     = r_resp_tag;

endmodule
`default_nettype wire

// File: tb/tb_div_request_ctrl.sv
`default_nettype none
// ============================================================================
// tb_div_request_ctrl : directed self-checking bench with a behavioural divider.
// Revision: 1.0
// ============================================================================
module tb_div_request_ctrl;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 5;
  localparam int CORE_LAT = 3;
  localparam int NORM_LAT = CORE_LAT + 4;

  logic             CLK;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             div_valid;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;
  logic             div_done;

  int n_checks = 0;
  int n_errors = 0;
  int dv_count = 0;
  logic zero_div_seen = 1'b0;
  int core_cnt;

  div_request_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .busy(busy),
    .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural unsigned divider: done pulses CORE_LAT+1 cycles after the start.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt      <= 0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_valid) begin
        core_cnt      <= CORE_LAT;
        div_quotient  <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
        div_remainder <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      end else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) div_done <= 1'b1;
      end
    end
  end

  always @(posedge CLK) begin
    if (div_valid) begin
      dv_count <= dv_count + 1;
      if (div_divisor == 0) zero_div_seen <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input int exp_lat, input int exp_pulses);
    int v0;
    int cyc;
    @(negedge CLK);
    v0 = dv_count;
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(negedge CLK);
    req_valid = 1'b0;
    wait_resp(cyc);
    check({name, "_lat"}, cyc, exp_lat);
    check({name, "_data"}, resp_data, exp);
    check({name, "_tag"}, {27'd0, resp_tag}, {27'd0, tag});
    check({name, "_pulses"}, dv_count - v0, exp_pulses);
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    check({name, "_release"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    int cyc;
    int v0;
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_rs1 = '0; req_rs2 = '0;
    req_tag = '0; kill = 1'b0; resp_ready = 1'b0;

    @(negedge CLK);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", {27'd0, resp_tag}, 32'd0);
    check("rst_div_valid", {31'd0, div_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 5'd1, 32'd14, NORM_LAT, 1);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 5'd2, 32'd2,  NORM_LAT, 1);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, NORM_LAT, 1);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, NORM_LAT, 1);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, NORM_LAT, 1);
    run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd6, 32'd14, NORM_LAT, 1);
    run_op("divu_big_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, NORM_LAT, 1);
    run_op("div_5_0",     2'b00, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0",    2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 1, 0);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1, 0);

    // Flush while the core is running, with a second kill inside DRAIN.
    @(negedge CLK);
    v0 = dv_count;
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd12;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    kill = 1'b1;
    @(negedge CLK);
    check("kill_drain_ready", {31'd0, req_ready}, 32'd0);
    check("kill_drain_busy", {31'd0, busy}, 32'd1);
    cnt = 0; bad = 0;
    while (busy && cnt < 50) begin
      @(negedge CLK);
      kill = 1'b0;
      cnt++;
      if (resp_valid || (busy && req_ready)) bad++;
    end
    check("kill_drain_cycles", cnt, 3);
    check("kill_no_resp", bad, 0);
    check("kill_pulses", dv_count - v0, 1);
    run_op("divu_9_3_after_kill", 2'b01, 32'd9, 32'd3, 5'd13, 32'd3, NORM_LAT, 1);

    // Writeback stall with a competing request held on the input.
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd10; req_tag = 5'd14;
    @(negedge CLK);
    req_valid = 1'b0;
    wait_resp(cyc);
    check("hold_first_lat", cyc, NORM_LAT);
    v0 = dv_count;
    req_valid = 1'b1; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_data", resp_data, 32'd100);
      check("hold_tag", {27'd0, resp_tag}, 32'd14);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    check("hold_no_launch", dv_count - v0, 0);
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    check("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_resp(cyc);
    check("b2b_data", resp_data, 32'd10);
    check("b2b_tag", {27'd0, resp_tag}, 32'd15);
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;

    // Kill wins over resp_ready while a response is pending.
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd5; req_rs2 = 32'd0; req_tag = 5'd16;
    @(negedge CLK);
    req_valid = 1'b0;
    check("kresp_valid", {31'd0, resp_valid}, 32'd1);
    kill = 1'b1; resp_ready = 1'b1;
    @(negedge CLK);
    kill = 1'b0; resp_ready = 1'b0;
    check("kresp_dropped", {31'd0, resp_valid}, 32'd0);
    check("kresp_idle", {31'd0, busy}, 32'd0);

    // Kill in IDLE blocks acceptance.
    req_valid = 1'b1; kill = 1'b1; req_op = 2'b01; req_rs1 = 32'd8; req_rs2 = 32'd2;
    @(negedge CLK);
    req_valid = 1'b0; kill = 1'b0;
    check("kill_idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while waiting on the core.
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd17;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_div_valid", {31'd0, div_valid}, 32'd0);
    check("arst_dividend", div_dividend, 32'd0);
    check("arst_tag", {27'd0, resp_tag}, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    run_op("remu_after_rst", 2'b11, 32'd23, 32'd5, 5'd18, 32'd3, NORM_LAT, 1);

    check("divisor_nonzero_on_launch", {31'd0, zero_div_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
